// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to a
// variable-latency instruction memory, buffers responses and drives IF/ID.
module fetch_stage #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instruction
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_KILL  = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] tag;

  logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;

  logic room_fetch;
  logic room_wait;
  logic accept;
  logic push;
  logic pop;

  // Issue only when the buffer can absorb the word that will come back.
  assign room_fetch = (cnt < CW'(FIFO_DEPTH));
  assign room_wait  = ((cnt + CW'(1)) < CW'(FIFO_DEPTH));
  assign imem_req   = !reset && !redirect &&
                      (((state == S_FETCH) && room_fetch) ||
                       ((state == S_WAIT) && imem_rvalid && room_wait));
  assign imem_addr  = fetch_pc;
  assign accept     = imem_req && imem_ready;
  assign push       = (state == S_WAIT) && imem_rvalid && !redirect;
  assign pop        = !redirect && !stall && (cnt != CW'(0));

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (accept) state_next = S_WAIT;
        else        state_next = S_FETCH;
      end
      S_WAIT: begin
        // A redirect turns the outstanding word stale unless it lands this very cycle.
        if (redirect)         state_next = imem_rvalid ? S_FETCH : S_KILL;
        else if (imem_rvalid) state_next = accept ? S_WAIT : S_FETCH;
        else                  state_next = S_WAIT;
      end
      S_KILL: begin
        if (imem_rvalid) state_next = S_FETCH;
        else             state_next = S_KILL;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC;
      tag      <= '0;
    end else begin
      state <= state_next;
      if (redirect)    fetch_pc <= redirect_pc;
      else if (accept) fetch_pc <= fetch_pc + XLEN'(4);
      else             fetch_pc <= fetch_pc;
      if (accept) tag <= fetch_pc;
      else        tag <= tag;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= tag;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      else      wr_ptr <= wr_ptr;
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      else      rd_ptr <= rd_ptr;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_valid       <= 1'b0;
      if_id_pc          <= '0;
      if_id_instruction <= NOP;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
    end else if (stall) begin
      if_id_valid <= if_id_valid;
    end else if (pop) begin
      if_id_valid       <= 1'b1;
      if_id_pc          <= fifo_pc[rd_ptr];
      if_id_instruction <= fifo_instr[rd_ptr];
    end else begin
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model with random latency, scoreboard of fetched
// words, a per-cycle IF/ID model and a short table of hand-derived vectors.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;

  fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rvalid       (imem_rvalid),
    .imem_rdata        (imem_rdata),
    .stall             (stall),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .if_id_valid       (if_id_valid),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } sb_t;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_pc;
  } vec_t;

  sb_t         sb[$];
  int          n_pass;
  int          n_total;
  logic        exp_valid;
  logic [63:0] exp_pc;
  logic [31:0] exp_instr;
  logic [63:0] model_pc;
  logic        outst;
  logic        killed;
  logic [63:0] tag_pc;
  int          lat_cnt;
  int          lat_lo;
  int          lat_hi;
  logic        req_seen;
  logic [63:0] addr_seen;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[17:2], a[33:18]} ^ 32'h3C5A_96E1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Holds reset for two edges, checks reset values, releases on a falling edge.
  task automatic do_reset();
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    #1;
    chk("req_in_reset", {63'h0, imem_req}, 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_valid", {63'h0, if_id_valid}, 64'h0);
    chk("reset_pc", if_id_pc, 64'h0);
    chk("reset_instr", {32'h0, if_id_instruction}, 64'h13);
    @(negedge clk);
    reset     = 1'b0;
    exp_valid = 1'b0;
    exp_pc    = 64'h0;
    exp_instr = 32'h0000_0013;
    model_pc  = 64'h0;
    outst     = 1'b0;
    killed    = 1'b0;
    lat_cnt   = 0;
    sb.delete();
  endtask

  // One clock: drive inputs at the falling edge, model memory and IF/ID, check after the edge.
  task automatic cycle(input logic st, input logic rd, input logic [63:0] tgt, input logic rdy);
    logic rv;
    logic acc;
    sb_t  e;
    rv          = outst && (lat_cnt == 0);
    stall       = st;
    redirect    = rd;
    redirect_pc = tgt;
    imem_ready  = rdy;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(tag_pc) : 32'hDEAD_BEEF;
    #1;
    req_seen  = imem_req;
    addr_seen = imem_addr;
    if (rd) chk("no_req_on_redirect", {63'h0, imem_req}, 64'h0);
    if (imem_req && !rd) chk("one_outstanding", {63'h0, outst && !rv}, 64'h0);
    acc = imem_req && rdy && !rd;
    if (acc) chk("imem_addr", imem_addr, model_pc);

    if (rd) begin
      exp_valid = 1'b0;
      sb.delete();
    end else if (st) begin
      exp_valid = exp_valid;
    end else if (sb.size() > 0) begin
      e         = sb.pop_front();
      exp_valid = 1'b1;
      exp_pc    = e.pc;
      exp_instr = e.instr;
    end else begin
      exp_valid = 1'b0;
    end

    if (rv) begin
      if (!killed && !rd) sb.push_back('{pc: tag_pc, instr: mem_word(tag_pc)});
      outst  = 1'b0;
      killed = 1'b0;
    end else if (outst) begin
      lat_cnt--;
      if (rd) killed = 1'b1;
    end
    if (rd) model_pc = tgt;
    if (acc) begin
      outst    = 1'b1;
      killed   = 1'b0;
      tag_pc   = model_pc;
      lat_cnt  = $urandom_range(lat_hi, lat_lo) - 1;
      model_pc = model_pc + 64'd4;
    end

    @(posedge clk); #1;
    chk("if_id_valid", {63'h0, if_id_valid}, {63'h0, exp_valid});
    chk("if_id_pc", if_id_pc, exp_pc);
    chk("if_id_instr", {32'h0, if_id_instruction}, {32'h0, exp_instr});
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    logic found;
    n_pass  = 0;
    n_total = 0;
    lat_lo  = 1;
    lat_hi  = 1;
    tag_pc  = 64'h0;

    // Hand-derived trace: ready always, one-cycle latency, a stall on row 8.
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 64'd0,  1'b0, 64'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 64'd4,  1'b0, 64'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 64'd0,  1'b1, 64'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 64'd8,  1'b1, 64'd4};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 64'd12, 1'b0, 64'd4};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 64'd0,  1'b1, 64'd8};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 64'd16, 1'b1, 64'd12};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 64'd20, 1'b0, 64'd12};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 64'd0,  1'b0, 64'd12};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 64'd0,  1'b1, 64'd16};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 64'd24, 1'b1, 64'd20};

    reset = 1'b1;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].stall, tbl[i].redirect, 64'h0, 1'b1);
      chk($sformatf("tbl%0d_req", i), {63'h0, req_seen}, {63'h0, tbl[i].exp_req});
      if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), addr_seen, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), {63'h0, if_id_valid}, {63'h0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_pc", i), if_id_pc, tbl[i].exp_pc);
    end

    // Stall three cycles mid-stream: buffer fills and requests stop.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 64'h0, 1'b1);
    chk("stall_req_dropped", {63'h0, req_seen}, 64'h0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 64'h0, 1'b1);

    // Redirect while a slow response is outstanding: the stale word is dropped.
    lat_lo = 3;
    lat_hi = 3;
    do_reset();
    cycle(1'b0, 1'b0, 64'h0, 1'b1);
    cycle(1'b0, 1'b1, 64'h100, 1'b1);
    chk("redirect_bubble", {63'h0, if_id_valid}, 64'h0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle(1'b0, 1'b0, 64'h0, 1'b1);
      if (if_id_valid) found = 1'b1;
    end
    chk("redirect_target_seen", {63'h0, found}, 64'h1);
    chk("redirect_first_pc", if_id_pc, 64'h100);

    // Redirect together with stall: the flush wins.
    lat_lo = 1;
    lat_hi = 1;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 64'h0, 1'b1);
    cycle(1'b1, 1'b1, 64'h200, 1'b1);
    chk("flush_over_stall", {63'h0, if_id_valid}, 64'h0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle(1'b0, 1'b0, 64'h0, 1'b1);
      if (if_id_valid) found = 1'b1;
    end
    chk("flush_target_seen", {63'h0, found}, 64'h1);
    chk("flush_first_pc", if_id_pc, 64'h200);

    // Memory not ready for five cycles: request and address held.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 64'h0, 1'b0);
      chk("unready_req_held", {63'h0, req_seen}, 64'h1);
      chk("unready_addr_stable", addr_seen, 64'h0);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 64'h0, 1'b1);

    // Random readiness, latency 1-4, stalls and occasional redirects.
    lat_lo = 1;
    lat_hi = 4;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) == 0,
            $urandom_range(0, 29) == 0,
            64'h1000 + (64'($urandom_range(0, 1023)) << 2),
            $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
